// File: rtl/countdown_mmss.sv
// countdown_mmss
// Down-counting BCD mm:ss timer. A value is loaded from ld_* (each digit
// clamped to its legal range), then decremented once per tick while in RUN,
// with borrow rippling seconds-units -> seconds-tens -> minutes-units ->
// minutes-tens. Reaching 00:00 moves to EXPIRED and pulses done once.
//
// Ports
//   clkmain            main clock, all state changes on its rising edge
//   clear_n            asynchronous active-low reset
//   tick               one-cycle count enable (1 Hz strobe)
//   load               load the ld_* digits, return to IDLE
//   ld_min_t/ld_min_u  minutes tens/units to load (BCD)
//   ld_sec_t/ld_sec_u  seconds tens/units to load (BCD)
//   start / stop       start-or-resume / pause
//   min_t, min_u,
//   sec_t, sec_u       current digits
//   running            high while in RUN
//   expired            high while in EXPIRED
//   done               one-cycle pulse on reaching 00:00
module countdown_mmss (
  input  logic       clkmain,
  input  logic       clear_n,
  input  logic       tick,
  input  logic       load,
  input  logic [2:0] ld_min_t,
  input  logic [3:0] ld_min_u,
  input  logic [2:0] ld_sec_t,
  input  logic [3:0] ld_sec_u,
  input  logic       start,
  input  logic       stop,
  output logic [2:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       expired,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] min_t_reg, min_t_next;
  logic [3:0] min_u_reg, min_u_next;
  logic [2:0] sec_t_reg, sec_t_next;
  logic [3:0] sec_u_reg, sec_u_next;
  logic       done_reg, done_next;

  // Decremented value of the current digits, computed digit by digit.
  logic [2:0] dec_min_t;
  logic [3:0] dec_min_u;
  logic [2:0] dec_sec_t;
  logic [3:0] dec_sec_u;
  logic       borrow_su, borrow_st, borrow_mu;
  logic       cur_zero, dec_zero;

  always_comb begin
    borrow_su = (sec_u_reg == 4'd0);
    dec_sec_u = borrow_su ? 4'd9 : sec_u_reg - 4'd1;

    borrow_st = borrow_su && (sec_t_reg == 3'd0);
    dec_sec_t = sec_t_reg;
    if (borrow_su) dec_sec_t = (sec_t_reg == 3'd0) ? 3'd5 : sec_t_reg - 3'd1;

    borrow_mu = borrow_st && (min_u_reg == 4'd0);
    dec_min_u = min_u_reg;
    if (borrow_st) dec_min_u = (min_u_reg == 4'd0) ? 4'd9 : min_u_reg - 4'd1;

    // RUN is never entered at 00:00, so min_t is nonzero whenever it borrows.
    dec_min_t = borrow_mu ? min_t_reg - 3'd1 : min_t_reg;

    cur_zero = (min_t_reg == 3'd0) && (min_u_reg == 4'd0) &&
               (sec_t_reg == 3'd0) && (sec_u_reg == 4'd0);
    dec_zero = (dec_min_t == 3'd0) && (dec_min_u == 4'd0) &&
               (dec_sec_t == 3'd0) && (dec_sec_u == 4'd0);
  end

  always_comb begin
    state_next = state_reg;
    min_t_next = min_t_reg;
    min_u_next = min_u_reg;
    sec_t_next = sec_t_reg;
    sec_u_next = sec_u_reg;
    done_next  = 1'b0;

    if (load) begin
      min_t_next = (ld_min_t > 3'd5) ? 3'd5 : ld_min_t;
      min_u_next = (ld_min_u > 4'd9) ? 4'd9 : ld_min_u;
      sec_t_next = (ld_sec_t > 3'd5) ? 3'd5 : ld_sec_t;
      sec_u_next = (ld_sec_u > 4'd9) ? 4'd9 : ld_sec_u;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!stop && start && !cur_zero) state_next = RUN;
        end
        RUN: begin
          // Strict priority: a cycle carrying stop or start does not count.
          if (stop) begin
            state_next = PAUSE;
          end else if (!start && tick) begin
            min_t_next = dec_min_t;
            min_u_next = dec_min_u;
            sec_t_next = dec_sec_t;
            sec_u_next = dec_sec_u;
            if (dec_zero) begin
              state_next = EXPIRED;
              done_next  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!stop && start) state_next = RUN;
        end
        default: begin
          state_next = EXPIRED;
        end
      endcase
    end
  end

  always_ff @(posedge clkmain or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= IDLE;
      min_t_reg <= 3'd0;
      min_u_reg <= 4'd0;
      sec_t_reg <= 3'd0;
      sec_u_reg <= 4'd0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      min_t_reg <= min_t_next;
      min_u_reg <= min_u_next;
      sec_t_reg <= sec_t_next;
      sec_u_reg <= sec_u_next;
      done_reg  <= done_next;
    end
  end

  assign min_t   = min_t_reg;
  assign min_u   = min_u_reg;
  assign sec_t   = sec_t_reg;
  assign sec_u   = sec_u_reg;
  assign running = (state_reg == RUN);
  assign expired = (state_reg == EXPIRED);
  assign done    = done_reg;

endmodule
